// File: rtl/svm_txn_submitter_if.sv
// svm_txn_submitter_if
// Bundles the three handshakes around the transaction submitter:
//   - dependency beat stream      (s_valid/s_ready/s_is_read/s_addr/s_nodep/s_last/s_prog_id)
//   - scheduler transaction port  (owner_programID, read/write_dependencies, transaction_valid,
//                                  transaction_accepted, inserted_programID, has_conflict, conflicting_id)
//   - result port                 (r_valid/r_ready/r_status/r_prog_id/r_conflict_id/r_attempts)
// Modport master is the submitter itself (it masters the scheduler transaction);
// modport slave is the surrounding environment (beat producer, scheduler, result consumer).
interface svm_txn_submitter_if #(
  parameter int D = 1024
);
  logic              s_valid;
  logic              s_ready;
  logic              s_is_read;
  logic [63:0]       s_addr;
  logic              s_nodep;
  logic              s_last;
  logic [63:0]       s_prog_id;
  logic [63:0]       owner_programID;
  logic [D*64-1:0]   read_dependencies;
  logic [D*64-1:0]   write_dependencies;
  logic              transaction_valid;
  logic              transaction_accepted;
  logic [63:0]       inserted_programID;
  logic              has_conflict;
  logic [63:0]       conflicting_id;
  logic              r_valid;
  logic              r_ready;
  logic [2:0]        r_status;
  logic [63:0]       r_prog_id;
  logic [63:0]       r_conflict_id;
  logic [7:0]        r_attempts;

  modport master (
    input  s_valid, s_is_read, s_addr, s_nodep, s_last, s_prog_id,
    input  transaction_accepted, inserted_programID, has_conflict, conflicting_id,
    input  r_ready,
    output s_ready, owner_programID, read_dependencies, write_dependencies, transaction_valid,
    output r_valid, r_status, r_prog_id, r_conflict_id, r_attempts
  );

  modport slave (
    output s_valid, s_is_read, s_addr, s_nodep, s_last, s_prog_id,
    output transaction_accepted, inserted_programID, has_conflict, conflicting_id,
    output r_ready,
    input  s_ready, owner_programID, read_dependencies, write_dependencies, transaction_valid,
    input  r_valid, r_status, r_prog_id, r_conflict_id, r_attempts
  );
endinterface

// File: rtl/svm_txn_submitter.sv
// svm_txn_submitter
// Producer-side front end of the SVM scheduler transaction interface. Collects a stream of
// dependency beats into packed read/write slot vectors, issues the transaction with a one-cycle
// transaction_valid pulse, waits for accept/conflict (retrying after a fixed backoff on conflict,
// giving up after a timeout) and reports the outcome on a ready/valid result port.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - asynchronous active-high reset
//   bus  - svm_txn_submitter_if.master: beat stream in, scheduler transaction out, result out
// Result status codes: 0 ACCEPT, 1 CONFLICT, 2 TIMEOUT, 3 OVERFLOW, 4 ID_MISMATCH.
module svm_txn_submitter #(
  parameter int DEPS_PER_TRANSACTION = 1024,
  parameter int TIMEOUT_CYCLES       = 64,
  parameter int MAX_RETRIES          = 3,
  parameter int BACKOFF_CYCLES       = 8
) (
  input  logic                clk,
  input  logic                rst,
  svm_txn_submitter_if.master bus
);

  localparam int D      = DEPS_PER_TRANSACTION;
  localparam int VEC_W  = D * 64;
  localparam int CNT_W  = $clog2(D + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BO_W   = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [31:0] MAX_RETRIES_U = MAX_RETRIES;

  localparam logic [2:0] RS_ACCEPT   = 3'd0;
  localparam logic [2:0] RS_CONFLICT = 3'd1;
  localparam logic [2:0] RS_TIMEOUT  = 3'd2;
  localparam logic [2:0] RS_OVERFLOW = 3'd3;
  localparam logic [2:0] RS_ID_MISM  = 3'd4;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_REPORT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                s_ready_q, s_ready_d;
  logic                txn_valid_q, txn_valid_d;
  logic                r_valid_q, r_valid_d;
  logic [VEC_W-1:0]    rd_vec_q, rd_vec_d;
  logic [VEC_W-1:0]    wr_vec_q, wr_vec_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                ovf_q, ovf_d;
  logic [63:0]         owner_id_q, owner_id_d;
  logic [7:0]          attempts_q, attempts_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BO_W-1:0]     backoff_cnt_q, backoff_cnt_d;
  logic [63:0]         conflict_id_q, conflict_id_d;
  logic [2:0]          status_q, status_d;

  // Decoded conditions shared by the next-state and datapath logic.
  logic beat_fire;
  logic rd_full;
  logic wr_full;
  logic beat_drop;
  logic ovf_seen;
  logic in_wait;
  logic wait_conflict;
  logic wait_accept;
  logic wait_expired;
  logic retry_ok;
  logic backoff_done;
  logic result_taken;

  // Decode handshake and counter conditions for the current cycle.
  always_comb begin
    beat_fire     = bus.s_valid & s_ready_q;
    rd_full       = (rd_cnt_q == CNT_W'(D));
    wr_full       = (wr_cnt_q == CNT_W'(D));
    // A dependency beat whose slot vector is already full is dropped and poisons the transaction.
    beat_drop     = beat_fire & ~bus.s_nodep & (bus.s_is_read ? rd_full : wr_full);
    ovf_seen      = ovf_q | beat_drop;
    // Scheduler inputs only matter while waiting; conflict takes priority over accept.
    in_wait       = (state_q == ST_WAIT);
    wait_conflict = in_wait & bus.has_conflict;
    wait_accept   = in_wait & ~bus.has_conflict & bus.transaction_accepted;
    wait_expired  = in_wait & ~bus.has_conflict & ~bus.transaction_accepted &
                    (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    // attempts_q already counts the issue that just conflicted.
    retry_ok      = ({24'd0, attempts_q} <= MAX_RETRIES_U);
    backoff_done  = (state_q == ST_BACKOFF) & (backoff_cnt_q == BO_W'(BACKOFF_CYCLES - 1));
    result_taken  = r_valid_q & bus.r_ready;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (beat_fire && bus.s_last) begin
          state_d = ovf_seen ? ST_REPORT : ST_ISSUE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_conflict) begin
          state_d = retry_ok ? ST_BACKOFF : ST_REPORT;
        end else if (wait_accept || wait_expired) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_BACKOFF: state_d = backoff_done ? ST_ISSUE : ST_BACKOFF;
      ST_REPORT:  state_d = result_taken ? ST_COLLECT : ST_REPORT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // FSM outputs, computed from the next state so the output flops line up with the state.
  always_comb begin
    s_ready_d   = (state_d == ST_COLLECT);
    txn_valid_d = (state_d == ST_ISSUE);
    r_valid_d   = (state_d == ST_REPORT);
  end

  // Datapath next-state: slot vectors, counters, IDs and result status.
  always_comb begin
    rd_vec_d      = rd_vec_q;
    wr_vec_d      = wr_vec_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    ovf_d         = ovf_q;
    owner_id_d    = owner_id_q;
    attempts_d    = attempts_q;
    wait_cnt_d    = wait_cnt_q;
    backoff_cnt_d = backoff_cnt_q;
    conflict_id_d = conflict_id_q;
    status_d      = status_q;
    case (state_q)
      ST_COLLECT: begin
        ovf_d = ovf_seen;
        if (beat_fire && !bus.s_nodep && bus.s_is_read && !rd_full) begin
          rd_vec_d[32'(rd_cnt_q) * 32'd64 +: 64] = bus.s_addr;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (beat_fire && !bus.s_nodep && !bus.s_is_read && !wr_full) begin
          wr_vec_d[32'(wr_cnt_q) * 32'd64 +: 64] = bus.s_addr;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else begin
          rd_cnt_d = rd_cnt_q;
          wr_cnt_d = wr_cnt_q;
        end
        if (beat_fire && bus.s_last) begin
          owner_id_d = bus.s_prog_id;
          status_d   = ovf_seen ? RS_OVERFLOW : status_q;
        end else begin
          owner_id_d = owner_id_q;
        end
      end
      ST_ISSUE: begin
        attempts_d = (attempts_q == 8'hFF) ? attempts_q : attempts_q + 8'd1;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (wait_conflict) begin
          conflict_id_d = bus.conflicting_id;
          backoff_cnt_d = '0;
          status_d      = retry_ok ? status_q : RS_CONFLICT;
        end else if (wait_accept) begin
          status_d = (bus.inserted_programID == owner_id_q) ? RS_ACCEPT : RS_ID_MISM;
        end else if (wait_expired) begin
          status_d = RS_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_BACKOFF: begin
        if (backoff_done) begin
          backoff_cnt_d = '0;
        end else begin
          backoff_cnt_d = backoff_cnt_q + BO_W'(1);
        end
      end
      ST_REPORT: begin
        // Clearing happens on the consuming edge so the next COLLECT starts from empty vectors.
        if (result_taken) begin
          rd_vec_d      = '0;
          wr_vec_d      = '0;
          rd_cnt_d      = '0;
          wr_cnt_d      = '0;
          ovf_d         = 1'b0;
          attempts_d    = 8'd0;
          wait_cnt_d    = '0;
          backoff_cnt_d = '0;
          conflict_id_d = 64'd0;
          status_d      = RS_ACCEPT;
        end else begin
          status_d = status_q;
        end
      end
      default: begin
        status_d = status_q;
      end
    endcase
  end

  // Datapath and registered-output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready_q     <= 1'b0;
      txn_valid_q   <= 1'b0;
      r_valid_q     <= 1'b0;
      rd_vec_q      <= '0;
      wr_vec_q      <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      ovf_q         <= 1'b0;
      owner_id_q    <= 64'd0;
      attempts_q    <= 8'd0;
      wait_cnt_q    <= '0;
      backoff_cnt_q <= '0;
      conflict_id_q <= 64'd0;
      status_q      <= 3'd0;
    end else begin
      s_ready_q     <= s_ready_d;
      txn_valid_q   <= txn_valid_d;
      r_valid_q     <= r_valid_d;
      rd_vec_q      <= rd_vec_d;
      wr_vec_q      <= wr_vec_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      ovf_q         <= ovf_d;
      owner_id_q    <= owner_id_d;
      attempts_q    <= attempts_d;
      wait_cnt_q    <= wait_cnt_d;
      backoff_cnt_q <= backoff_cnt_d;
      conflict_id_q <= conflict_id_d;
      status_q      <= status_d;
    end
  end

  assign bus.s_ready            = s_ready_q;
  assign bus.transaction_valid  = txn_valid_q;
  assign bus.owner_programID    = owner_id_q;
  assign bus.read_dependencies  = rd_vec_q;
  assign bus.write_dependencies = wr_vec_q;
  assign bus.r_valid            = r_valid_q;
  assign bus.r_status           = status_q;
  assign bus.r_prog_id          = owner_id_q;
  assign bus.r_conflict_id      = conflict_id_q;
  assign bus.r_attempts         = attempts_q;

endmodule
